// File: rtl/phaethon_mem_pkg.sv
// Shared definitions for the Phaethon RAM controller: FSM encoding, the out-of-range
// read pattern and the address-range helper.
package phaethon_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } ctrlState_t;

  localparam logic [31:0] OOR_DEFAULT = 32'hDEADBEEF;
  localparam int WORD_LSB = 2;
  localparam int COUNT_W = 4;

  // True when every byte-address bit above the word index is zero.
  function automatic logic addrInRange(input logic [31:0] addr, input int depthLog2);
    return (addr >> (depthLog2 + WORD_LSB)) == 32'd0;
  endfunction

endpackage

// File: rtl/phaethon_word_array.sv
// 32-bit word store with one registered-read/write core port and one write-only load port.
// When both ports write the same word on one edge, the core write lands last and wins.
module phaethon_word_array #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  coreRe,
  input  logic                  coreWe,
  input  logic [DEPTH_LOG2-1:0] coreIdx,
  input  logic [31:0]           coreWrData,
  output logic [31:0]           coreRdData,
  input  logic                  loadWe,
  input  logic [DEPTH_LOG2-1:0] loadIdx,
  input  logic [31:0]           loadWrData
);

  logic [31:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (loadWe) mem[loadIdx] <= loadWrData;
    if (coreWe) mem[coreIdx] <= coreWrData;
    if (coreRe) coreRdData <= mem[coreIdx];
  end

endmodule

// File: rtl/phaethon_ram_ctrl.sv
// Fixed-latency RAM controller behind the Phaethon core memory interface, with a host
// load port that keeps working while reset is held.
module phaethon_ram_ctrl
  import phaethon_mem_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 10,
  parameter int          LATENCY    = 2,
  parameter logic [31:0] OOR_VALUE  = OOR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ramAddress,
  input  logic [31:0] ramOut,
  input  logic        readReq,
  input  logic        writeReq,
  output logic [31:0] ramIn,
  output logic        readAck,
  output logic        writeAck,
  input  logic        loadEn,
  input  logic [31:0] loadAddr,
  input  logic [31:0] loadData,
  output logic        busy,
  output logic [7:0]  dropCount
);

  localparam logic [COUNT_W-1:0] START_COUNT = COUNT_W'(LATENCY - 1);

  ctrlState_t            stateReg;
  logic [COUNT_W-1:0]    countReg;
  logic                  isWriteReg;
  logic                  inRangeReg;
  logic                  hasReadReg;
  logic                  oorLastReg;
  logic [DEPTH_LOG2-1:0] idxReg;
  logic [31:0]           dataReg;
  logic [31:0]           arrayRdData;
  logic                  dropEvent;
  logic                  coreRe;
  logic                  coreWe;
  logic                  loadWe;
  logic [1:0]            unusedLowBits;

  // Idle drops only the read half of a read+write pair; busy drops everything.
  assign dropEvent = (stateReg == IDLE) ? (readReq & writeReq) : (readReq | writeReq);
  assign coreRe = (stateReg == DONE) && !isWriteReg && inRangeReg;
  assign coreWe = (stateReg == DONE) && isWriteReg && inRangeReg;
  assign loadWe = loadEn && addrInRange(loadAddr, DEPTH_LOG2);
  assign unusedLowBits = ramAddress[1:0] ^ loadAddr[1:0];

  // ramIn is rebuilt from flags so the array output register needs no reset.
  assign ramIn = !hasReadReg ? 32'd0 : (oorLastReg ? OOR_VALUE : arrayRdData);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg   <= IDLE;
      countReg   <= '0;
      isWriteReg <= 1'b0;
      inRangeReg <= 1'b0;
      idxReg     <= '0;
      dataReg    <= '0;
      hasReadReg <= 1'b0;
      oorLastReg <= 1'b0;
      readAck    <= 1'b0;
      writeAck   <= 1'b0;
      busy       <= 1'b0;
      dropCount  <= 8'd0;
    end else begin
      readAck  <= 1'b0;
      writeAck <= 1'b0;
      if (dropEvent && dropCount != 8'hFF) dropCount <= dropCount + 8'd1;
      case (stateReg)
        IDLE: begin
          if (readReq || writeReq) begin
            isWriteReg <= writeReq;
            inRangeReg <= addrInRange(ramAddress, DEPTH_LOG2);
            idxReg     <= ramAddress[DEPTH_LOG2+1:WORD_LSB];
            dataReg    <= ramOut;
            countReg   <= START_COUNT;
            busy       <= 1'b1;
            stateReg   <= (LATENCY == 1) ? DONE : WAIT;
          end
        end
        WAIT: begin
          countReg <= countReg - COUNT_W'(1);
          if (countReg == COUNT_W'(1)) stateReg <= DONE;
        end
        DONE: begin
          if (isWriteReg) begin
            writeAck <= 1'b1;
          end else begin
            readAck    <= 1'b1;
            hasReadReg <= 1'b1;
            oorLastReg <= !inRangeReg;
          end
          busy     <= 1'b0;
          stateReg <= IDLE;
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

  phaethon_word_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) wordArray (
    .clk        (clk),
    .coreRe     (coreRe),
    .coreWe     (coreWe),
    .coreIdx    (idxReg),
    .coreWrData (dataReg),
    .coreRdData (arrayRdData),
    .loadWe     (loadWe),
    .loadIdx    (loadAddr[DEPTH_LOG2+1:WORD_LSB]),
    .loadWrData (loadData)
  );

endmodule

// File: tb/tb_phaethon_ram_ctrl.sv
// Directed bench for phaethon_ram_ctrl: instance 0 uses LATENCY=2, instance 1 uses LATENCY=1.
// Expected acks are queued at request time and matched by a negedge monitor.
module tb_phaethon_ram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  reset, readReq, writeReq, loadEn, readAck, writeAck, busy;
  logic [31:0] ramAddress [2];
  logic [31:0] ramOut [2];
  logic [31:0] loadAddr [2];
  logic [31:0] loadData [2];
  logic [31:0] ramIn [2];
  logic [7:0]  dropCount [2];

  int errors = 0;
  int checks = 0;
  int cycleCnt = 0;

  typedef struct {
    int          dut;
    logic        isWrite;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sbq[$];
  logic [31:0] model [2][1024];

  phaethon_ram_ctrl #(.DEPTH_LOG2(10), .LATENCY(2), .OOR_VALUE(32'hDEADBEEF)) dut2 (
    .clk(clk), .reset(reset[0]), .ramAddress(ramAddress[0]), .ramOut(ramOut[0]),
    .readReq(readReq[0]), .writeReq(writeReq[0]), .ramIn(ramIn[0]), .readAck(readAck[0]),
    .writeAck(writeAck[0]), .loadEn(loadEn[0]), .loadAddr(loadAddr[0]), .loadData(loadData[0]),
    .busy(busy[0]), .dropCount(dropCount[0])
  );

  phaethon_ram_ctrl #(.DEPTH_LOG2(10), .LATENCY(1), .OOR_VALUE(32'hDEADBEEF)) dut1 (
    .clk(clk), .reset(reset[1]), .ramAddress(ramAddress[1]), .ramOut(ramOut[1]),
    .readReq(readReq[1]), .writeReq(writeReq[1]), .ramIn(ramIn[1]), .readAck(readAck[1]),
    .writeAck(writeAck[1]), .loadEn(loadEn[1]), .loadAddr(loadAddr[1]), .loadData(loadData[1]),
    .busy(busy[1]), .dropCount(dropCount[1])
  );

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  function automatic int lat(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic logic [31:0] expRead(input int d, input logic [31:0] addr);
    return (addr[31:12] == 20'd0) ? model[d][addr[11:2]] : 32'hDEADBEEF;
  endfunction

  function automatic logic [31:0] pat(input int i);
    return 32'h00000A01 + 32'(i) * 32'h00010003;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
    end
  endtask

  // Must be called at the negedge where the request is driven.
  task automatic push(input int d, input logic w, input logic [31:0] data);
    sbq.push_back('{dut: d, isWrite: w, data: data, due: cycleCnt + 1 + lat(d)});
  endtask

  task automatic req(input int d, input logic rd, input logic wr,
                     input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    readReq[d] = rd;
    writeReq[d] = wr;
    ramAddress[d] = addr;
    ramOut[d] = data;
    if (wr) begin
      push(d, 1'b1, 32'd0);
      if (addr[31:12] == 20'd0) model[d][addr[11:2]] = data;
    end else begin
      push(d, 1'b0, expRead(d, addr));
    end
    @(negedge clk);
    readReq[d] = 1'b0;
    writeReq[d] = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 16 && sbq.size() != 0; i++) @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (readAck[d] || writeAck[d]) begin
        chk("ackExclusive", 32'(readAck[d] & writeAck[d]), 32'd0);
        checks++;
        assert (sbq.size() != 0) else begin
          errors++;
          $error("FAIL unexpectedAck: observed ack on dut%0d, expected none pending", d);
        end
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("ackDut", 32'(d), 32'(e.dut));
          chk("ackKind", 32'(writeAck[d]), 32'(e.isWrite));
          chk("ackCycle", 32'(cycleCnt), 32'(e.due));
          if (!e.isWrite) chk("readData", ramIn[d], e.data);
        end
      end
    end
    if (sbq.size() != 0) begin
      checks++;
      assert (cycleCnt <= sbq[0].due) else begin
        errors++;
        $error("FAIL ackTimeout: observed no ack by cycle %0d, expected by cycle %0d",
               cycleCnt, sbq[0].due);
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 2'b11;
    readReq = 2'b00;
    writeReq = 2'b00;
    loadEn = 2'b00;
    for (int d = 0; d < 2; d++) begin
      ramAddress[d] = 32'd0;
      ramOut[d] = 32'd0;
      loadAddr[d] = 32'd0;
      loadData[d] = 32'd0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rstRamIn", ramIn[d], 32'd0);
      chk("rstReadAck", 32'(readAck[d]), 32'd0);
      chk("rstWriteAck", 32'(writeAck[d]), 32'd0);
      chk("rstBusy", 32'(busy[d]), 32'd0);
      chk("rstDrop", 32'(dropCount[d]), 32'd0);
    end

    // Program image loaded while reset is held; then one out-of-range load that must vanish.
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      loadEn = 2'b11;
      for (int d = 0; d < 2; d++) begin
        loadAddr[d] = 32'(i * 4);
        loadData[d] = pat(i);
        model[d][i] = pat(i);
      end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      loadAddr[d] = 32'h00001000;
      loadData[d] = 32'hBAD0BAD0;
    end
    @(negedge clk);
    loadEn = 2'b00;
    reset = 2'b00;
    @(negedge clk);

    // 1: read latency and busy window
    req(0, 1'b1, 1'b0, 32'h0, 32'h0);
    chk("t1BusyE0", 32'(busy[0]), 32'd1);
    @(negedge clk);
    chk("t1BusyE1", 32'(busy[0]), 32'd1);
    chk("t1NoAckE1", 32'(readAck[0]), 32'd0);
    @(negedge clk);
    chk("t1AckE2", 32'(readAck[0]), 32'd1);
    chk("t1RamIn", ramIn[0], 32'h00000A01);
    chk("t1BusyE2", 32'(busy[0]), 32'd0);
    @(negedge clk);
    chk("t1AckOneCycle", 32'(readAck[0]), 32'd0);
    chk("t1RamInHold", ramIn[0], 32'h00000A01);

    // 2: write then read with ignored low address bits
    req(0, 1'b0, 1'b1, 32'h10, 32'h12345678);
    drain();
    chk("t2WriteKeepsRamIn", ramIn[0], 32'h00000A01);
    req(0, 1'b1, 1'b0, 32'h13, 32'h0);
    drain();
    chk("t2ReadBack", ramIn[0], 32'h12345678);

    // 3: out-of-range read and write, then full scan of the array
    req(0, 1'b1, 1'b0, 32'h00100000, 32'h0);
    drain();
    chk("t3OorRead", ramIn[0], 32'hDEADBEEF);
    req(0, 1'b0, 1'b1, 32'h00100000, 32'hFFFFFFFF);
    drain();
    for (int i = 0; i < 1024; i++) begin
      req(0, 1'b1, 1'b0, 32'(i * 4), 32'h0);
      drain();
    end

    // 4: read+write collision, then drops while busy
    @(negedge clk);
    readReq[0] = 1'b1;
    writeReq[0] = 1'b1;
    ramAddress[0] = 32'h20;
    ramOut[0] = 32'h55;
    push(0, 1'b1, 32'd0);
    model[0][8] = 32'h55;
    @(negedge clk);
    chk("t4DropCollide", 32'(dropCount[0]), 32'd1);
    writeReq[0] = 1'b0;
    @(negedge clk);
    chk("t4DropBusy", 32'(dropCount[0]), 32'd2);
    writeReq[0] = 1'b1;
    @(negedge clk);
    chk("t4DropBusyPair", 32'(dropCount[0]), 32'd3);
    readReq[0] = 1'b0;
    writeReq[0] = 1'b0;
    drain();
    req(0, 1'b1, 1'b0, 32'h20, 32'h0);
    drain();

    // Hold read+write high: accepted every third edge, every edge drops.
    ramAddress[0] = 32'h24;
    ramOut[0] = 32'h99;
    for (int i = 0; i < 258; i++) begin
      @(negedge clk);
      readReq[0] = 1'b1;
      writeReq[0] = 1'b1;
      if (i % 3 == 0) begin
        push(0, 1'b1, 32'd0);
        model[0][9] = 32'h99;
      end
    end
    @(negedge clk);
    readReq[0] = 1'b0;
    writeReq[0] = 1'b0;
    drain();
    chk("t4DropSaturate", 32'(dropCount[0]), 32'd255);
    req(0, 1'b1, 1'b0, 32'h24, 32'h0);
    drain();

    // 5: reset one cycle before a write commit
    @(negedge clk);
    writeReq[0] = 1'b1;
    ramAddress[0] = 32'h8;
    ramOut[0] = 32'h77;
    @(negedge clk);
    writeReq[0] = 1'b0;
    @(negedge clk);
    reset[0] = 1'b1;
    #1;
    chk("t5RstBusy", 32'(busy[0]), 32'd0);
    chk("t5RstRamIn", ramIn[0], 32'd0);
    chk("t5RstDrop", 32'(dropCount[0]), 32'd0);
    chk("t5RstReadAck", 32'(readAck[0]), 32'd0);
    @(negedge clk);
    chk("t5NoWriteAck", 32'(writeAck[0]), 32'd0);
    reset[0] = 1'b0;
    req(0, 1'b1, 1'b0, 32'h8, 32'h0);
    drain();
    chk("t5WordKept", ramIn[0], pat(2));

    // 6: LATENCY=1 back-to-back reads on alternate cycles
    req(1, 1'b1, 1'b0, 32'h0, 32'h0);
    req(1, 1'b1, 1'b0, 32'h4, 32'h0);
    req(1, 1'b1, 1'b0, 32'h8, 32'h0);
    drain();
    chk("t6NoDrops", 32'(dropCount[1]), 32'd0);

    // Core write and load hit word 1 on the same edge: core data must win.
    @(negedge clk);
    writeReq[1] = 1'b1;
    ramAddress[1] = 32'h4;
    ramOut[1] = 32'hC0DE0004;
    push(1, 1'b1, 32'd0);
    model[1][1] = 32'hC0DE0004;
    @(negedge clk);
    writeReq[1] = 1'b0;
    loadEn[1] = 1'b1;
    loadAddr[1] = 32'h4;
    loadData[1] = 32'h11111111;
    @(negedge clk);
    loadEn[1] = 1'b0;
    drain();
    req(1, 1'b1, 1'b0, 32'h4, 32'h0);
    drain();

    // Read commit and load on the same edge: read returns the old word.
    @(negedge clk);
    readReq[1] = 1'b1;
    ramAddress[1] = 32'h8;
    push(1, 1'b0, expRead(1, 32'h8));
    @(negedge clk);
    readReq[1] = 1'b0;
    loadEn[1] = 1'b1;
    loadAddr[1] = 32'h8;
    loadData[1] = 32'h22222222;
    model[1][2] = 32'h22222222;
    @(negedge clk);
    loadEn[1] = 1'b0;
    drain();
    req(1, 1'b1, 1'b0, 32'h8, 32'h0);
    drain();
    chk("t6LoadVisible", ramIn[1], 32'h22222222);
    chk("t6DropsEnd", 32'(dropCount[1]), 32'd0);

    @(negedge clk);
    chk("sbEmpty", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
